intr_ctrl: RTL and testbench
============================

// Module: intr_ctrl
// PURPOSE
//  Interrupt request controller; drives the CPU's intr input and consumes its inta acknowledge.
//  Edge-detects N_SRC peripheral lines, holds them as pending, applies a CPU-writable mask,
//  and raises intr to the single-cycle CPU.
//  On inta it latches the winning source ID as cause and clears that pending bit.
//  It then blocks further requests until the handler signals end-of-interrupt (eoi).
// PARAMETERS
//  N_SRC  4  number of interrupt source lines
//  ID_W   2  width of cause ID, must equal clog2(N_SRC)
// PORTS
//  Clk         in   1      clock; all state updates on rising edge
//  Clrn        in   1      reset; synchronous, active-high (Clrn=1 at a rising edge clears all state)
//  irq_in      in   N_SRC  raw peripheral request lines, level, synchronous to Clk
//  mask_we     in   1      write strobe for mask register
//  mask_wdata  in   N_SRC  new mask value; bit=1 blocks that source
//  inta        in   1      acknowledge from CPU
//  eoi         in   1      end-of-interrupt pulse from CPU (eret)
//  intr        out  1      interrupt request to CPU, registered
//  cause       out  ID_W   ID of the acknowledged source, valid while busy=1
//  busy        out  1      1 from ack until eoi (handler in progress)
//  pending     out  N_SRC  current pending register, for software read
// BEHAVIOUR
//  Reset values: intr=0, cause=0, busy=0, pending=0, mask=all-ones (all blocked), irq_q=0, state=IDLE.
//  Edge detection:
//   - irq_q <= irq_in each cycle.
//   - rise = irq_in & ~irq_q.
//   - pending[i] <= (pending[i] & ~clr[i]) | rise[i], so a set in the same cycle as a clear wins.
//   - A level held high produces one pending set only.
//  Mask: mask <= mask_wdata when mask_we; takes effect the cycle after the write.
//  Masking never clears pending. Eligibility: elig = pending & ~mask.
//  Priority: lowest index wins (bit 0 highest).
//  FSM states IDLE, REQ, SERVICE (registered):
//   IDLE:
//    - if |elig, go to REQ next cycle.
//    - intr=1 from that edge, one cycle after elig is seen.
//   REQ:
//    - intr=1.
//    - If inta=1: cause <= prio(elig) sampled this cycle, clr[cause]=1, busy <= 1, intr <= 0, go to SERVICE.
//    - Else if elig==0 (masked after request): intr <= 0, go to IDLE. No ack, no cause update.
//    - inta and elig==0 in the same cycle: treat as elig==0, i.e. spurious; go to IDLE, cause unchanged.
//   SERVICE:
//    - intr=0 even if new elig arrives; new edges still set pending.
//    - On eoi=1: busy <= 0, go to IDLE.
//    - If elig is nonzero at that point, REQ follows one cycle later.
//  Ignored inputs: inta outside REQ; eoi outside SERVICE.
//  Latency: rise on irq_in -> pending set next edge -> REQ/intr one edge later; 2 cycles min.
//  Back-to-back requests: eoi-to-next-intr is 1 cycle.
//  Reset mid-operation: any state returns to IDLE on the reset edge.
//   - All pending requests are lost; the mask returns to all-ones.
//  cause holds its last value outside busy; only its value while busy=1 is defined.
// TESTING
//  1. Reset, mask_we with 4'b0000, irq_in[2] rises at cycle t
//     -> pending=4'b0100 at t+1, intr=1 at t+2.
//     Then inta 1 cycle -> cause=2, busy=1, intr=0, pending=0.
//  2. irq_in[1] and irq_in[3] rise together, mask=0
//     -> first ack gives cause=1, pending=4'b1000.
//     Then eoi -> intr=1 again one cycle later; second ack gives cause=3.
//  3. mask=4'b0001, irq_in[0] rises -> pending=4'b0001, intr stays 0.
//     Then write mask=0 -> intr=1 two edges after the write.
//  4. In REQ for source 2, write mask=4'b0100 before inta
//     -> intr drops, state IDLE, pending[2] still 1, busy=0.
//  5. During SERVICE, irq_in[0] rises -> pending[0]=1, intr=0 until eoi, then intr=1.
//     A late inta in SERVICE has no effect.
//  6. Clrn=1 while in REQ with pending=4'b0110
//     -> next edge: intr=0, busy=0, pending=0, mask=4'b1111.

Source files
------------

// File: rtl/intr_ctrl.sv
// -----------------------------------------------------------------------------
// intr_ctrl -- interrupt request controller for a single-cycle CPU.
//
// Edge-detects N_SRC peripheral request lines into a pending register, applies
// a CPU-writable mask, and raises a registered interrupt request. When the CPU
// acknowledges, the winning source ID (lowest index first) is latched as the
// cause and that pending bit is cleared. Further requests are held off until
// the handler signals end-of-interrupt.
//
// Ports:
//   Clk         in   1      clock, rising edge
//   Clrn        in   1      synchronous active-high reset
//   irq_in      in   N_SRC  raw level request lines, synchronous to Clk
//   mask_we     in   1      mask register write strobe
//   mask_wdata  in   N_SRC  new mask value (bit=1 blocks that source)
//   inta        in   1      interrupt acknowledge from CPU
//   eoi         in   1      end-of-interrupt pulse from CPU
//   intr        out  1      interrupt request to CPU (registered)
//   cause       out  ID_W   acknowledged source ID, valid while busy=1
//   busy        out  1      handler in progress (ack until eoi)
//   pending     out  N_SRC  pending register, for software read
// -----------------------------------------------------------------------------
module intr_ctrl #(
  parameter int N_SRC = 4,
  parameter int ID_W  = 2
) (
  input  logic             Clk,
  input  logic             Clrn,
  input  logic [N_SRC-1:0] irq_in,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_wdata,
  input  logic             inta,
  input  logic             eoi,
  output logic             intr,
  output logic [ID_W-1:0]  cause,
  output logic             busy,
  output logic [N_SRC-1:0] pending
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [N_SRC-1:0] irq_q;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic             intr_q, intr_d;
  logic [ID_W-1:0]  cause_q, cause_d;
  logic             busy_q, busy_d;

  logic [N_SRC-1:0] rise_s;
  logic [N_SRC-1:0] elig_s;
  logic [N_SRC-1:0] clr_s;

  // Lowest-index set bit wins; returns 0 when no bit is set.
  function automatic logic [ID_W-1:0] prio(input logic [N_SRC-1:0] vec);
    logic [ID_W-1:0] id;
    id = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (vec[i]) begin
        id = ID_W'(i);
      end else begin
        id = id;
      end
    end
    return id;
  endfunction

  assign rise_s = irq_in & ~irq_q;
  assign elig_s = pending_q & ~mask_q;

  // Next-state, output and pending-clear decode.
  always_comb begin
    state_d = state_q;
    intr_d  = intr_q;
    cause_d = cause_q;
    busy_d  = busy_q;
    clr_s   = '0;
    mask_d  = mask_we ? mask_wdata : mask_q;
    case (state_q)
      ST_IDLE: begin
        if (|elig_s) begin
          state_d = ST_REQ;
          intr_d  = 1'b1;
        end else begin
          intr_d  = 1'b0;
        end
      end
      ST_REQ: begin
        // Loss of eligibility takes precedence over a simultaneous ack:
        // that ack is spurious and must not disturb cause.
        if (elig_s == '0) begin
          state_d = ST_IDLE;
          intr_d  = 1'b0;
        end else if (inta) begin
          state_d        = ST_SERVICE;
          intr_d         = 1'b0;
          busy_d         = 1'b1;
          cause_d        = prio(elig_s);
          clr_s[prio(elig_s)] = 1'b1;
        end else begin
          intr_d  = 1'b1;
        end
      end
      ST_SERVICE: begin
        intr_d = 1'b0;
        if (eoi) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        intr_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
    // A new edge in the same cycle as its clear keeps the bit set.
    pending_d = (pending_q & ~clr_s) | rise_s;
  end

  // State registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Clrn) begin
      state_q   <= ST_IDLE;
      irq_q     <= '0;
      pending_q <= '0;
      mask_q    <= '1;
      intr_q    <= 1'b0;
      cause_q   <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      irq_q     <= irq_in;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      intr_q    <= intr_d;
      cause_q   <= cause_d;
      busy_q    <= busy_d;
    end
  end

  assign intr    = intr_q;
  assign cause   = cause_q;
  assign busy    = busy_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl; expected values are hand-derived from the
// block's described timing (inputs applied 1 time unit after a rising edge,
// outputs checked 1 time unit after the following edge).
module tb_intr_ctrl;

  logic       Clk;
  logic       Clrn;
  logic [3:0] irq_in;
  logic       mask_we;
  logic [3:0] mask_wdata;
  logic       inta;
  logic       eoi;
  logic       intr;
  logic [1:0] cause;
  logic       busy;
  logic [3:0] pending;

  int checks;
  int errors;

  intr_ctrl #(.N_SRC(4), .ID_W(2)) dut (
    .Clk        (Clk),
    .Clrn       (Clrn),
    .irq_in     (irq_in),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .inta       (inta),
    .eoi        (eoi),
    .intr       (intr),
    .cause      (cause),
    .busy       (busy),
    .pending    (pending)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    Clrn       = 1'b1;
    irq_in     = 4'b0000;
    mask_we    = 1'b0;
    mask_wdata = 4'b0000;
    inta       = 1'b0;
    eoi        = 1'b0;
    tick();
    tick();
    Clrn = 1'b0;
    check_val("rst_intr", {31'd0, intr}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_pend", {28'd0, pending}, 32'd0);
    check_val("rst_cause", {30'd0, cause}, 32'd0);

    // 1: single source 2, full path to ack and eoi
    mask_we = 1'b1; mask_wdata = 4'b0000;
    tick();
    mask_we = 1'b0;
    irq_in = 4'b0100;
    tick();
    check_val("t1_pend", {28'd0, pending}, 32'h4);
    check_val("t1_intr_early", {31'd0, intr}, 32'd0);
    tick();
    check_val("t1_intr", {31'd0, intr}, 32'd1);
    inta = 1'b1;
    tick();
    inta = 1'b0;
    check_val("t1_cause", {30'd0, cause}, 32'd2);
    check_val("t1_busy", {31'd0, busy}, 32'd1);
    check_val("t1_intr_ack", {31'd0, intr}, 32'd0);
    check_val("t1_pend_clr", {28'd0, pending}, 32'd0);
    tick();
    check_val("t1_level_once", {28'd0, pending}, 32'd0);
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    check_val("t1_eoi_busy", {31'd0, busy}, 32'd0);
    irq_in = 4'b0000;
    tick();
    check_val("t1_idle_intr", {31'd0, intr}, 32'd0);

    // 2: sources 1 and 3 together; priority then back-to-back
    irq_in = 4'b1010;
    tick();
    check_val("t2_pend", {28'd0, pending}, 32'ha);
    tick();
    check_val("t2_intr", {31'd0, intr}, 32'd1);
    inta = 1'b1;
    tick();
    inta = 1'b0;
    check_val("t2_cause1", {30'd0, cause}, 32'd1);
    check_val("t2_pend_left", {28'd0, pending}, 32'h8);
    tick();
    check_val("t2_svc_intr", {31'd0, intr}, 32'd0);
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    check_val("t2_eoi_intr", {31'd0, intr}, 32'd0);
    check_val("t2_eoi_busy", {31'd0, busy}, 32'd0);
    tick();
    check_val("t2_reintr", {31'd0, intr}, 32'd1);
    inta = 1'b1;
    tick();
    inta = 1'b0;
    check_val("t2_cause3", {30'd0, cause}, 32'd3);
    check_val("t2_pend_empty", {28'd0, pending}, 32'd0);
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    irq_in = 4'b0000;
    tick();

    // 3: masked source pends silently, unmask releases it
    mask_we = 1'b1; mask_wdata = 4'b0001;
    tick();
    mask_we = 1'b0;
    irq_in = 4'b0001;
    tick();
    check_val("t3_pend", {28'd0, pending}, 32'h1);
    check_val("t3_intr_masked0", {31'd0, intr}, 32'd0);
    tick();
    check_val("t3_intr_masked1", {31'd0, intr}, 32'd0);
    mask_we = 1'b1; mask_wdata = 4'b0000;
    tick();
    mask_we = 1'b0;
    check_val("t3_intr_wr_edge", {31'd0, intr}, 32'd0);
    tick();
    check_val("t3_intr_unmask", {31'd0, intr}, 32'd1);
    inta = 1'b1;
    tick();
    inta = 1'b0;
    check_val("t3_cause0", {30'd0, cause}, 32'd0);
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    irq_in = 4'b0000;
    tick();

    // 4: mask written while in REQ withdraws the request
    irq_in = 4'b0100;
    tick();
    tick();
    check_val("t4_intr_req", {31'd0, intr}, 32'd1);
    mask_we = 1'b1; mask_wdata = 4'b0100;
    tick();
    mask_we = 1'b0;
    check_val("t4_intr_wr_edge", {31'd0, intr}, 32'd1);
    tick();
    check_val("t4_intr_drop", {31'd0, intr}, 32'd0);
    check_val("t4_pend_kept", {28'd0, pending}, 32'h4);
    check_val("t4_busy", {31'd0, busy}, 32'd0);
    check_val("t4_cause_kept", {30'd0, cause}, 32'd0);
    inta = 1'b1;
    tick();
    inta = 1'b0;
    check_val("t4_stray_inta", {31'd0, busy}, 32'd0);
    mask_we = 1'b1; mask_wdata = 4'b0000;
    tick();
    mask_we = 1'b0;
    tick();
    check_val("t4_reintr", {31'd0, intr}, 32'd1);
    inta = 1'b1;
    tick();
    inta = 1'b0;
    check_val("t4_cause2", {30'd0, cause}, 32'd2);
    check_val("t4_busy_ack", {31'd0, busy}, 32'd1);

    // 5: new edge during SERVICE pends but waits for eoi
    irq_in = 4'b0001;
    tick();
    check_val("t5_pend", {28'd0, pending}, 32'h1);
    check_val("t5_intr_svc", {31'd0, intr}, 32'd0);
    inta = 1'b1;
    tick();
    inta = 1'b0;
    check_val("t5_late_inta_cause", {30'd0, cause}, 32'd2);
    check_val("t5_late_inta_pend", {28'd0, pending}, 32'h1);
    check_val("t5_late_inta_intr", {31'd0, intr}, 32'd0);
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    check_val("t5_eoi_busy", {31'd0, busy}, 32'd0);
    check_val("t5_eoi_intr", {31'd0, intr}, 32'd0);
    tick();
    check_val("t5_intr_after", {31'd0, intr}, 32'd1);
    inta = 1'b1;
    tick();
    inta = 1'b0;
    check_val("t5_cause0", {30'd0, cause}, 32'd0);
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    irq_in = 4'b0000;
    tick();

    // 6: reset while in REQ
    irq_in = 4'b0110;
    tick();
    check_val("t6_pend", {28'd0, pending}, 32'h6);
    tick();
    check_val("t6_intr_req", {31'd0, intr}, 32'd1);
    Clrn = 1'b1;
    tick();
    Clrn = 1'b0;
    check_val("t6_rst_intr", {31'd0, intr}, 32'd0);
    check_val("t6_rst_busy", {31'd0, busy}, 32'd0);
    check_val("t6_rst_pend", {28'd0, pending}, 32'd0);
    // Lines still high: edge detector was cleared, so they pend again,
    // but the restored all-ones mask keeps intr low.
    tick();
    check_val("t6_repend", {28'd0, pending}, 32'h6);
    tick();
    check_val("t6_mask_ones", {31'd0, intr}, 32'd0);
    tick();
    check_val("t6_mask_ones2", {31'd0, intr}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
